// File: rtl/udp_arb_pkg.sv
// Shared types and the round-robin pick function for the UDP TX arbiter.
// Requester indices are always 3 bits wide, so up to 8 requesters are supported.
package udp_arb_pkg;

  localparam int unsigned MAX_N = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
  } udp_hdr_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Returns the first asserted request at or after ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                       input logic [IDX_W-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned p;
    r = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      p = 32'(ptr) + i;
      if (p >= n) p = p - n;
      if (i < n && !r.found && req[IDX_W'(p)]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(p);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/udp_tx_arb_rr_arbiter.sv
// Round-robin request picker.
// The pointer advances past the acknowledged index only when ack is asserted.
module rr_arbiter
  import udp_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  output logic [IDX_W-1:0] pick_idx_c,
  output logic             pick_found_c
);

  logic [IDX_W-1:0] ptr;
  rr_pick_t         pick;

  always_comb begin
    pick         = rr_pick(MAX_N'(req), ptr, N);
    pick_idx_c   = pick.idx;
    pick_found_c = pick.found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (ack) begin
      ptr <= (ack_idx == IDX_W'(N - 1)) ? '0 : ack_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/udp_tx_arb.sv
// Frame-level round-robin arbiter that shares the UDP TX header/payload input
// between N requesters, with a watchdog that cuts off stalled payload streams.
module udp_tx_arb
  import udp_arb_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      s_udp_hdr_valid,
  output logic [N-1:0]      s_udp_hdr_ready,
  input  logic [32*N-1:0]   s_udp_ip_dest_ip,
  input  logic [16*N-1:0]   s_udp_source_port,
  input  logic [16*N-1:0]   s_udp_dest_port,
  input  logic [16*N-1:0]   s_udp_length,
  input  logic [8*N-1:0]    s_udp_payload_axis_tdata,
  input  logic [N-1:0]      s_udp_payload_axis_tvalid,
  output logic [N-1:0]      s_udp_payload_axis_tready,
  input  logic [N-1:0]      s_udp_payload_axis_tlast,
  input  logic [N-1:0]      s_udp_payload_axis_tuser,
  output logic              m_udp_hdr_valid,
  input  logic              m_udp_hdr_ready,
  output logic [31:0]       m_udp_ip_dest_ip,
  output logic [15:0]       m_udp_source_port,
  output logic [15:0]       m_udp_dest_port,
  output logic [15:0]       m_udp_length,
  output logic [7:0]        m_udp_payload_axis_tdata,
  output logic              m_udp_payload_axis_tvalid,
  input  logic              m_udp_payload_axis_tready,
  output logic              m_udp_payload_axis_tlast,
  output logic              m_udp_payload_axis_tuser,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              busy,
  output logic              timeout_abort
);

  localparam int unsigned DATA_W = 8;

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("udp_tx_arb: N must be in 2..8");
  end
  if (TIMEOUT != 0 && CNT_W < $clog2(TIMEOUT + 1)) begin : g_bad_cnt
    $error("udp_tx_arb: CNT_W too narrow for TIMEOUT");
  end

  state_t           state;
  udp_hdr_t         hdr;
  logic [CNT_W-1:0] cnt;
  logic             abort_pend;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              hdr_done;
  logic [N-1:0]      g_onehot;
  logic [DATA_W-1:0] sel_tdata;
  logic              sel_tvalid;
  logic              sel_tlast;
  logic              sel_tuser;
  logic              beat;

  rr_arbiter #(.N(N)) u_rr (
    .clk          (clk),
    .rst          (rst),
    .req          (s_udp_hdr_valid),
    .ack          (hdr_done),
    .ack_idx      (grant_idx),
    .pick_idx_c   (pick_idx),
    .pick_found_c (pick_found)
  );

  // Granted requester's payload lane.
  assign g_onehot   = N'(1) << grant_idx;
  assign sel_tdata  = DATA_W'(s_udp_payload_axis_tdata >> {grant_idx, 3'b000});
  assign sel_tvalid = 1'(s_udp_payload_axis_tvalid >> grant_idx);
  assign sel_tlast  = 1'(s_udp_payload_axis_tlast >> grant_idx);
  assign sel_tuser  = 1'(s_udp_payload_axis_tuser >> grant_idx);

  assign hdr_done = (state == HDR) && m_udp_hdr_ready;
  assign beat     = (state == PAY) && !abort_pend && sel_tvalid && m_udp_payload_axis_tready;
  assign busy     = (state != IDLE);

  assign m_udp_hdr_valid   = (state == HDR);
  assign m_udp_ip_dest_ip  = hdr.dest_ip;
  assign m_udp_source_port = hdr.src_port;
  assign m_udp_dest_port   = hdr.dst_port;
  assign m_udp_length      = hdr.length;

  // Header accept, payload mux and drain sink; everything is gated off during reset.
  always_comb begin
    s_udp_hdr_ready           = '0;
    s_udp_payload_axis_tready = '0;
    m_udp_payload_axis_tdata  = '0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = 1'b0;
    m_udp_payload_axis_tuser  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (pick_found) s_udp_hdr_ready = N'(1) << pick_idx;
        end
        PAY: begin
          if (abort_pend) begin
            m_udp_payload_axis_tvalid = 1'b1;
            m_udp_payload_axis_tlast  = 1'b1;
            m_udp_payload_axis_tuser  = 1'b1;
          end else begin
            m_udp_payload_axis_tdata  = sel_tdata;
            m_udp_payload_axis_tvalid = sel_tvalid;
            m_udp_payload_axis_tlast  = sel_tlast;
            m_udp_payload_axis_tuser  = sel_tuser;
            s_udp_payload_axis_tready = m_udp_payload_axis_tready ? g_onehot : '0;
          end
        end
        DRAIN: s_udp_payload_axis_tready = g_onehot;
        default: ;
      endcase
    end
  end

  // Frame FSM, header capture and payload watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant_idx     <= '0;
      hdr           <= '0;
      cnt           <= '0;
      abort_pend    <= 1'b0;
      timeout_abort <= 1'b0;
    end else begin
      timeout_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx    <= pick_idx;
            hdr.dest_ip  <= 32'(s_udp_ip_dest_ip >> {pick_idx, 5'b00000});
            hdr.src_port <= 16'(s_udp_source_port >> {pick_idx, 4'b0000});
            hdr.dst_port <= 16'(s_udp_dest_port >> {pick_idx, 4'b0000});
            hdr.length   <= 16'(s_udp_length >> {pick_idx, 4'b0000});
            state        <= HDR;
          end
        end
        HDR: begin
          if (m_udp_hdr_ready) begin
            cnt        <= '0;
            abort_pend <= 1'b0;
            state      <= PAY;
          end
        end
        PAY: begin
          if (abort_pend) begin
            if (m_udp_payload_axis_tready) begin
              abort_pend    <= 1'b0;
              timeout_abort <= 1'b1;
              state         <= DRAIN;
            end
          end else if (beat) begin
            cnt <= '0;
            if (sel_tlast) state <= IDLE;
          end else if (TIMEOUT != 0) begin
            if (cnt == CNT_W'(TIMEOUT - 1)) abort_pend <= 1'b1;
            else                            cnt        <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (sel_tvalid && sel_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Scoreboard bench for udp_tx_arb with N=2 and a 16-cycle payload watchdog.
module tb_udp_tx_arb;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    s_udp_hdr_valid = '0;
  logic [N-1:0]    s_udp_hdr_ready;
  logic [32*N-1:0] s_udp_ip_dest_ip = '0;
  logic [16*N-1:0] s_udp_source_port = '0;
  logic [16*N-1:0] s_udp_dest_port = '0;
  logic [16*N-1:0] s_udp_length = '0;
  logic [8*N-1:0]  s_td = '0;
  logic [N-1:0]    s_tv = '0;
  logic [N-1:0]    s_tr;
  logic [N-1:0]    s_tl = '0;
  logic [N-1:0]    s_tu = '0;
  logic            m_hv;
  logic            m_hr = 1'b1;
  logic [31:0]     m_ip;
  logic [15:0]     m_sp, m_dp, m_len;
  logic [7:0]      m_td;
  logic            m_tv;
  logic            m_tr = 1'b1;
  logic            m_tl, m_tu;
  logic [2:0]      grant_idx;
  logic            busy, timeout_abort;
  logic            tog = 1'b0;

  udp_tx_arb #(.N(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_udp_ip_dest_ip(s_udp_ip_dest_ip), .s_udp_source_port(s_udp_source_port),
    .s_udp_dest_port(s_udp_dest_port), .s_udp_length(s_udp_length),
    .s_udp_payload_axis_tdata(s_td), .s_udp_payload_axis_tvalid(s_tv),
    .s_udp_payload_axis_tready(s_tr), .s_udp_payload_axis_tlast(s_tl),
    .s_udp_payload_axis_tuser(s_tu),
    .m_udp_hdr_valid(m_hv), .m_udp_hdr_ready(m_hr),
    .m_udp_ip_dest_ip(m_ip), .m_udp_source_port(m_sp),
    .m_udp_dest_port(m_dp), .m_udp_length(m_len),
    .m_udp_payload_axis_tdata(m_td), .m_udp_payload_axis_tvalid(m_tv),
    .m_udp_payload_axis_tready(m_tr), .m_udp_payload_axis_tlast(m_tl),
    .m_udp_payload_axis_tuser(m_tu),
    .grant_idx(grant_idx), .busy(busy), .timeout_abort(timeout_abort)
  );

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] ip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
  } hexp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } bexp_t;

  hexp_t hq[$];
  bexp_t bq[$];
  int    total  = 0;
  int    bad    = 0;
  int    aborts = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Downstream payload ready: constant 1 or toggling every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tr = tog ? ~m_tr : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT transfers a header or a beat.
  initial begin
    hexp_t hg, he;
    bexp_t bg, be;
    forever begin
      @(negedge clk);
      if (m_hv && m_hr) begin
        hg = {grant_idx, m_ip, m_sp, m_dp, m_len};
        total++;
        if (hq.size() == 0) begin
          bad++;
          $display("FAIL hdr_unexpected got=%h", hg);
        end else begin
          he = hq.pop_front();
          if (hg !== he) begin
            bad++;
            $display("FAIL hdr got=%h exp=%h", hg, he);
          end
        end
      end
      if (m_tv && m_tr) begin
        bg = {m_td, m_tl, m_tu};
        total++;
        if (bq.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected got data=%0h last=%0b user=%0b", m_td, m_tl, m_tu);
        end else begin
          be = bq.pop_front();
          if (bg !== be) begin
            bad++;
            $display("FAIL beat got data=%0h last=%0b user=%0b exp data=%0h last=%0b user=%0b",
                     bg.d, bg.l, bg.u, be.d, be.l, be.u);
          end
        end
      end
      if (timeout_abort) aborts++;
    end
  end

  task automatic set_hdr(input logic r, input logic [31:0] ip, input logic [15:0] sp,
                         input logic [15:0] dp, input logic [15:0] len);
    s_udp_ip_dest_ip[{r, 5'b00000} +: 32] = ip;
    s_udp_source_port[{r, 4'b0000} +: 16] = sp;
    s_udp_dest_port[{r, 4'b0000} +: 16]   = dp;
    s_udp_length[{r, 4'b0000} +: 16]      = len;
    s_udp_hdr_valid[r]                    = 1'b1;
    hq.push_back({{2'b00, r}, ip, sp, dp, len});
  endtask

  task automatic wait_hdr(input logic r);
    logic ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = s_udp_hdr_ready[r];
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL hdr_accept_timeout req=%0d got=0 exp=1", r);
    end else begin
      chk("hdr_ready_onehot", 64'($countones(s_udp_hdr_ready)), 64'd1);
    end
    @(posedge clk);
    #1;
    s_udp_hdr_valid[r] = 1'b0;
  endtask

  task automatic beat(input logic r, input logic [7:0] d, input logic l, input logic u,
                      input logic push);
    logic ok = 1'b0;
    s_td[{r, 3'b000} +: 8] = d;
    s_tl[r] = l;
    s_tu[r] = u;
    s_tv[r] = 1'b1;
    if (push) bq.push_back({d, l, u});
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = s_tr[r];
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_accept_timeout req=%0d data=%0h got=0 exp=1", r, d);
    end
    @(posedge clk);
    #1;
    s_tv[r] = 1'b0;
    s_tl[r] = 1'b0;
    s_tu[r] = 1'b0;
  endtask

  task automatic frame(input logic r, input logic [7:0] base, input int n, input logic ulast);
    for (int i = 0; i < n; i++)
      beat(r, base + 8'(i), (i == n - 1), ulast && (i == n - 1), 1'b1);
  endtask

  initial begin
    int gap;
    logic found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_mvalid", 64'({m_hv, m_tv, m_tl, m_tu}), 64'd0);
    chk("rst_readies", 64'({s_udp_hdr_ready, s_tr}), 64'd0);
    chk("rst_abort", 64'(timeout_abort), 64'd0);
    @(posedge clk);
    #1;

    // Both headers at once: req0, then req1, then req0 again
    set_hdr(1'b0, 32'h0A00_0001, 16'd100, 16'd200, 16'd11);
    set_hdr(1'b1, 32'hC0A8_0002, 16'd300, 16'd400, 16'd10);
    wait_hdr(1'b0);
    frame(1'b0, 8'h10, 3, 1'b0);
    wait_hdr(1'b1);
    set_hdr(1'b0, 32'h0A00_0003, 16'd101, 16'd201, 16'd10);
    frame(1'b1, 8'h20, 2, 1'b0);
    wait_hdr(1'b0);
    frame(1'b0, 8'h30, 2, 1'b0);

    // req1 only, 10-byte payload, downstream header ready held low for 3 cycles
    m_hr = 1'b0;
    set_hdr(1'b1, 32'hC0A8_0105, 16'd5555, 16'd1234, 16'd18);
    wait_hdr(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hdr_hold_valid", 64'(m_hv), 64'd1);
      chk("hdr_hold_fields", {m_ip, m_dp, m_sp}, {32'hC0A8_0105, 16'd1234, 16'd5555});
    end
    @(posedge clk);
    #1;
    m_hr = 1'b1;
    frame(1'b1, 8'h01, 10, 1'b0);

    // Downstream tready toggling
    tog = 1'b1;
    set_hdr(1'b0, 32'h0A00_0010, 16'd7, 16'd8, 16'd14);
    wait_hdr(1'b0);
    frame(1'b0, 8'h40, 6, 1'b0);
    tog = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Watchdog: req0 stalls after 3 beats
    set_hdr(1'b0, 32'h0A00_0020, 16'd9, 16'd10, 16'd20);
    wait_hdr(1'b0);
    for (int i = 0; i < 3; i++) beat(1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
    bq.push_back({8'h00, 1'b1, 1'b1});
    found = 1'b0;
    gap = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (m_tv) begin
        found = 1'b1;
        gap = k;
      end
    end
    chk("timeout_gap", 64'(gap), 64'd17);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_once", 64'(aborts), 64'd1);
    for (int i = 0; i < 4; i++) beat(1'b0, 8'hE0 + 8'(i), (i == 3), 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_exit_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    set_hdr(1'b1, 32'hC0A8_0030, 16'd11, 16'd12, 16'd10);
    wait_hdr(1'b1);
    frame(1'b1, 8'hB0, 2, 1'b0);

    // Reset during payload beat 5
    set_hdr(1'b0, 32'h0A00_0040, 16'd13, 16'd14, 16'd16);
    wait_hdr(1'b0);
    for (int i = 0; i < 4; i++) beat(1'b0, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b1);
    s_td[7:0] = 8'h64;
    s_tv[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gates_tvalid", 64'(m_tv), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tv[0] = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_readies", 64'({s_udp_hdr_ready, s_tr, m_hv}), 64'd0);
    chk("midrst_queues", 64'(hq.size() + bq.size()), 64'd0);
    @(posedge clk);
    #1;
    set_hdr(1'b1, 32'hC0A8_0050, 16'd15, 16'd16, 16'd11);
    wait_hdr(1'b1);
    frame(1'b1, 8'hC0, 3, 1'b0);

    // Requester tuser on its last beat passes through, no abort
    set_hdr(1'b0, 32'h0A00_0060, 16'd17, 16'd18, 16'd10);
    wait_hdr(1'b0);
    frame(1'b0, 8'h50, 2, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("end_hdr_queue", 64'(hq.size()), 64'd0);
    chk("end_beat_queue", 64'(bq.size()), 64'd0);
    chk("end_abort_count", 64'(aborts), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
